// File: rtl/readout_frontend_pkg.sv
// Shared definitions for the readout bin quantizer front-end.
// Holds the default parameter values, the FSM state type and the helper
// that sizes the per-bin accumulators.
package readout_frontend_pkg;

    localparam int DEF_SAMPLE_W        = 16;
    localparam int DEF_SAMPLES_PER_BIN = 8;
    localparam int DEF_NUM_BINS        = 16;
    localparam int DEF_CODE_W          = 2;
    localparam int DEF_SHIFT           = 13;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // A sum of samples_per_bin values cannot overflow this width.
    function automatic int acc_width(input int sample_w, input int samples_per_bin);
        return sample_w + $clog2(samples_per_bin);
    endfunction

endpackage

// File: rtl/readout_code_clamp.sv
// Quantizes one bin sum to an unsigned CODE_W-bit code:
//   code = clamp((sum >>> SHIFT) + 2^(CODE_W-1), 0, 2^CODE_W-1)
// Ports:
//   sum   in  ACC_W   signed bin sum
//   code  out CODE_W  saturated unsigned code
module readout_code_clamp #(
    parameter int ACC_W  = 19,
    parameter int CODE_W = 2,
    parameter int SHIFT  = 13
) (
    input  logic signed [ACC_W-1:0]  sum,
    output logic        [CODE_W-1:0] code
);

    // One extra bit so adding the bias can never wrap.
    localparam logic signed [ACC_W:0] BIAS = (ACC_W+1)'(1 << (CODE_W - 1));
    localparam logic signed [ACC_W:0] MAXC = (ACC_W+1)'((1 << CODE_W) - 1);

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] biased;

    always_comb begin
        wide    = {sum[ACC_W-1], sum};
        shifted = wide >>> SHIFT;
        biased  = shifted + BIAS;
        if (biased[ACC_W]) begin
            code = '0;
        end else if (biased > MAXC) begin
            code = '1;
        end else begin
            code = biased[CODE_W-1:0];
        end
    end

endmodule

// File: rtl/readout_bin_quantizer_frontend.sv
// Streaming front-end: integrates NUM_BINS windows of SAMPLES_PER_BIN I/Q
// samples, quantizes each window sum and presents the packed feature vector
// on a valid/ready output held stable until accepted.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   s_valid/s_ready/s_i/s_q/s_last  sample stream in
//   m_valid/m_ready/m_data      packed feature vector out
//   err_len                     sticky trace-length error
//
// state | meaning
// ACCUM | accepting samples, integrating bins
// HOLD  | vector presented, waiting for m_ready
// DRAIN | discarding the tail of an over-long trace up to s_last
module readout_bin_quantizer_frontend
    import readout_frontend_pkg::*;
#(
    parameter int SAMPLE_W        = DEF_SAMPLE_W,
    parameter int SAMPLES_PER_BIN = DEF_SAMPLES_PER_BIN,
    parameter int NUM_BINS        = DEF_NUM_BINS,
    parameter int CODE_W          = DEF_CODE_W,
    parameter int SHIFT           = DEF_SHIFT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [SAMPLE_W-1:0]      s_i,
    input  logic signed [SAMPLE_W-1:0]      s_q,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_BINS*2*CODE_W-1:0]    m_data,
    output logic                            err_len
);

    localparam int ACC_W  = acc_width(SAMPLE_W, SAMPLES_PER_BIN);
    localparam int EXT_W  = ACC_W - SAMPLE_W;
    localparam int SC_W   = $clog2(SAMPLES_PER_BIN);
    localparam int BIN_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int DATA_W = NUM_BINS * 2 * CODE_W;

    state_t                   state;
    logic [SC_W-1:0]          samp_cnt;
    logic [BIN_W-1:0]         bin_cnt;
    logic signed [ACC_W-1:0]  acc_i, acc_q;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic [CODE_W-1:0]        code_i, code_q;
    logic [DATA_W-1:0]        feat_q, feat_nxt;
    logic                     drain_pending;
    logic                     accept, bin_done, last_bin;

    assign accept   = s_valid && s_ready;
    assign bin_done = (samp_cnt == SC_W'(SAMPLES_PER_BIN - 1));
    assign last_bin = (bin_cnt == BIN_W'(NUM_BINS - 1));
    assign sum_i    = acc_i + $signed({{EXT_W{s_i[SAMPLE_W-1]}}, s_i});
    assign sum_q    = acc_q + $signed({{EXT_W{s_q[SAMPLE_W-1]}}, s_q});

    readout_code_clamp #(.ACC_W(ACC_W), .CODE_W(CODE_W), .SHIFT(SHIFT)) u_clamp_i (
        .sum  (sum_i),
        .code (code_i)
    );

    readout_code_clamp #(.ACC_W(ACC_W), .CODE_W(CODE_W), .SHIFT(SHIFT)) u_clamp_q (
        .sum  (sum_q),
        .code (code_q)
    );

    // Frame under construction with the current bin's codes merged in;
    // m_data only takes it as a whole, so a discarded frame never leaks out.
    always_comb begin
        feat_nxt = feat_q;
        feat_nxt[int'(bin_cnt)*2*CODE_W +: CODE_W]          = code_i;
        feat_nxt[int'(bin_cnt)*2*CODE_W + CODE_W +: CODE_W] = code_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCUM;
            samp_cnt      <= '0;
            bin_cnt       <= '0;
            acc_i         <= '0;
            acc_q         <= '0;
            feat_q        <= '0;
            m_data        <= '0;
            m_valid       <= 1'b0;
            s_ready       <= 1'b0;
            err_len       <= 1'b0;
            drain_pending <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (s_last && !(bin_done && last_bin)) begin
                            err_len  <= 1'b1;
                            samp_cnt <= '0;
                            bin_cnt  <= '0;
                            acc_i    <= '0;
                            acc_q    <= '0;
                        end else if (bin_done) begin
                            samp_cnt <= '0;
                            acc_i    <= '0;
                            acc_q    <= '0;
                            feat_q   <= feat_nxt;
                            if (last_bin) begin
                                bin_cnt <= '0;
                                m_data  <= feat_nxt;
                                m_valid <= 1'b1;
                                s_ready <= 1'b0;
                                state   <= HOLD;
                                if (!s_last) begin
                                    err_len       <= 1'b1;
                                    drain_pending <= 1'b1;
                                end
                            end else begin
                                bin_cnt <= bin_cnt + BIN_W'(1);
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SC_W'(1);
                            acc_i    <= sum_i;
                            acc_q    <= sum_q;
                        end
                    end
                end
                HOLD: begin
                    s_ready <= 1'b0;
                    if (m_ready) begin
                        m_valid       <= 1'b0;
                        s_ready       <= 1'b1;
                        drain_pending <= 1'b0;
                        state         <= drain_pending ? DRAIN : ACCUM;
                    end
                end
                DRAIN: begin
                    s_ready <= 1'b1;
                    if (accept && s_last) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
